ps2_rx_fifo: RTL

Parametrised successor to the PS/2 device-to-host receive path. It adds several things over the current path: a glitch filter on ps2_clk, odd-parity and stop-bit checking, an inter-edge timeout watchdog, optional E0/F0 prefix folding, and a FIFO with a valid/ready output handshake. It sits between the keyboard pins and data_control-style consumers, which read decoded key events at their own pace.

---
 rtl/ps2_rx_fifo.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: filtered PS/2 receiver with parity/stop/timeout checks, E0/F0 folding and an FWFT event FIFO
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int FIFO_DEPTH     = 4,
  parameter int DECODE_PREFIX  = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ps2_clk,
  input  logic                             ps2_data,
  output logic [7:0]                       scan_code,
  output logic                             scan_code_ext,
  output logic                             scan_code_break,
  output logic                             scan_code_valid,
  input  logic                             scan_code_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             parity_error,
  output logic                             frame_error,
  output logic                             overflow
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, next;
  logic clk_s1, clk_s2, dat_s1, dat_s2, filt, fall, timeout;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic par, acc, stop_bad, par_bad, accept, frame_bad;
  logic ext_p, brk_p, is_pfx, push, pop, full, wr;
  logic [9:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      {clk_s1, clk_s2, dat_s1, dat_s2, filt} <= '1;
      fcnt <= '0;
    end else begin
      {clk_s2, clk_s1} <= {clk_s1, ps2_clk};
      {dat_s2, dat_s1} <= {dat_s1, ps2_data};
      fcnt <= (clk_s2 != filt && fcnt != FW'(FILTER_LEN - 1)) ? fcnt + 1'b1 : '0;
      if (clk_s2 != filt && fcnt == FW'(FILTER_LEN - 1)) filt <= ~filt;
    end
  end
  assign fall    = filt && !clk_s2 && fcnt == FW'(FILTER_LEN - 1);
  assign timeout = state != IDLE && tcnt == TW'(TIMEOUT_CYCLES);
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = timeout ? IDLE :
           !fall ? state :
           state == IDLE ? (dat_s2 ? IDLE : DATA) :
           state == DATA ? (bit_cnt == 3'd7 ? PARITY : DATA) :
           state == PARITY ? STOP : IDLE;
  end
  always_comb begin
    stop_bad  = fall && state == STOP && !dat_s2;
    par_bad   = fall && state == STOP && dat_s2 && !(^{shreg, par});
    accept    = fall && state == STOP && dat_s2 && (^{shreg, par});
    frame_bad = stop_bad || timeout;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      par <= 1'b0;
      acc <= 1'b0;
      parity_error <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      tcnt <= (state == IDLE || fall || timeout) ? '0 : tcnt + 1'b1;
      if (fall && state == IDLE) bit_cnt <= '0;
      if (fall && state == DATA) begin
        shreg <= {dat_s2, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (fall && state == PARITY) par <= dat_s2;
      acc <= accept;
      parity_error <= par_bad;
      frame_error <= frame_bad;
    end
  end
  // shreg still holds the accepted byte in the cycle after the stop bit
  assign is_pfx = DECODE_PREFIX != 0 && (shreg == 8'hE0 || shreg == 8'hF0);
  assign push   = acc && !is_pfx;
  always_ff @(posedge clk) begin
    if (rst || par_bad || frame_bad) begin
      ext_p <= 1'b0;
      brk_p <= 1'b0;
    end else if (acc) begin
      ext_p <= is_pfx ? (ext_p || shreg == 8'hE0) : 1'b0;
      brk_p <= is_pfx ? (brk_p || shreg == 8'hF0) : 1'b0;
    end
  end
  assign full = cnt == CW'(FIFO_DEPTH);
  assign pop  = scan_code_valid && scan_code_ready;
  assign wr   = push && (!full || pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) begin
        mem[wp] <= {ext_p, brk_p, shreg};
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(wr) - CW'(pop);
      overflow <= push && full && !pop;
    end
  end
  assign {scan_code_ext, scan_code_break, scan_code} = mem[rp];
  assign scan_code_valid = cnt != '0;
  assign fifo_count      = cnt;
endmodule
